// File: rtl/memory_dumper_pkg.sv
// memory_dumper_pkg
//   Shared definitions for the UART/SDRAM loader and dumper blocks:
//   4-bit state encodings, header length and UART byte width.
package memory_dumper_pkg;

    localparam int HDR_BYTES = 8;
    localparam int BYTE_W    = 8;
    localparam int HDR_W     = HDR_BYTES * BYTE_W;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RX_HDR  = 4'd1;
    localparam logic [3:0] ST_LATCH   = 4'd2;
    localparam logic [3:0] ST_RD_WAIT = 4'd3;
    localparam logic [3:0] ST_TX_BYTE = 4'd4;
    localparam logic [3:0] ST_TX_WAIT = 4'd5;
    localparam logic [3:0] ST_NEXT    = 4'd6;

    // Top-level sequencer. The byte handshake (TX_BYTE/TX_WAIT) lives in the
    // serializer, so the top only sees one "transmitting" state.
    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_RX_HDR  = ST_RX_HDR,
        S_LATCH   = ST_LATCH,
        S_RD_WAIT = ST_RD_WAIT,
        S_TX      = ST_TX_BYTE,
        S_NEXT    = ST_NEXT
    } dump_state_t;

    typedef enum logic [3:0] {
        SER_IDLE = ST_IDLE,
        SER_BYTE = ST_TX_BYTE,
        SER_WAIT = ST_TX_WAIT
    } ser_state_t;

endpackage

// File: rtl/memory_dumper_if.sv
// memory_dumper_if
//   UART rx/tx and SDRAM read-port signals of the memory dumper.
//   master : dumper side (drives tx_req/tx_data/rd_req/rd_addr)
//   slave  : UART + SDRAM controller side
interface memory_dumper_if #(parameter int DATA_W = 32);
    logic              rx_ack;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_req;
    logic [7:0]        tx_data;
    logic              rd_req;
    logic [31:0]       rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_fin;

    modport master (
        input  rx_ack, rx_data, tx_ready, rd_data, rd_fin,
        output tx_req, tx_data, rd_req, rd_addr
    );

    modport slave (
        output rx_ack, rx_data, tx_ready, rd_data, rd_fin,
        input  tx_req, tx_data, rd_req, rd_addr
    );
endinterface

// File: rtl/memory_dumper_serializer.sv
// uart_tx_serializer
//   Sends one DATA_W word over the UART byte interface, MSB first.
//   clk/reset_n : clock (falling-edge state updates), async active-low reset
//   en          : low freezes everything; tx_req is never raised while low
//   load/word   : capture a word (only accepted when idle)
//   ready       : UART tx idle
//   tx_req/data : one-cycle byte strobe and byte
//   done        : combinational pulse, last byte accepted by the UART
module uart_tx_serializer
    import memory_dumper_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              ready,
    output logic              tx_req,
    output logic [BYTE_W-1:0] tx_data,
    output logic              done
);
    localparam int NB = DATA_W / BYTE_W;
    localparam int CW = $clog2(NB + 1);

    ser_state_t        st, st_n;
    logic [DATA_W-1:0] word_buf, word_buf_n;
    logic [CW-1:0]     byte_rem, byte_rem_n;
    logic              tx_req_n;
    logic [BYTE_W-1:0] tx_data_n;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= SER_IDLE;
            word_buf <= '0;
            byte_rem <= '0;
            tx_req   <= 1'b0;
            tx_data  <= '0;
        end else begin
            st       <= st_n;
            word_buf <= word_buf_n;
            byte_rem <= byte_rem_n;
            tx_req   <= tx_req_n;
            tx_data  <= tx_data_n;
        end
    end

    always_comb begin
        st_n       = st;
        word_buf_n = word_buf;
        byte_rem_n = byte_rem;
        tx_req_n   = 1'b0;     // strobe: high for one cycle only
        tx_data_n  = tx_data;
        done       = 1'b0;
        if (en) begin
            case (st)
                SER_IDLE: if (load) begin
                    word_buf_n = word;
                    byte_rem_n = CW'(NB);
                    st_n       = SER_BYTE;
                end
                SER_BYTE: if (ready) begin
                    tx_req_n   = 1'b1;
                    tx_data_n  = word_buf[DATA_W-1 -: BYTE_W];
                    word_buf_n = word_buf << BYTE_W;
                    byte_rem_n = byte_rem - CW'(1);
                    st_n       = SER_WAIT;
                end
                // The UART drops ready once it has taken the byte; that is
                // the only proof of acceptance, so wait for it.
                SER_WAIT: if (!ready) begin
                    if (byte_rem == '0) begin
                        done = 1'b1;
                        st_n = SER_IDLE;
                    end else begin
                        st_n = SER_BYTE;
                    end
                end
                default: st_n = SER_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/memory_dumper.sv
// memory_dumper
//   UART-driven SDRAM read-back. Host sends 8 header bytes (start address,
//   then word count, both MSB first); the block reads that many words and
//   streams them back over UART, MSB first.
//   clk     : system clock, state updates on the falling edge
//   reset_n : asynchronous active-low reset
//   req     : enable; low freezes the block (tx_req forced low)
//   busy    : high whenever not IDLE
//   bus     : UART rx/tx and SDRAM read port (master side)
module memory_dumper
    import memory_dumper_pkg::*;
#(
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int          DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req,
    output logic                busy,
    memory_dumper_if.master     bus
);
    dump_state_t      state, state_n;
    logic [HDR_W-1:0] hdr, hdr_n;
    logic [2:0]       hdr_rem, hdr_rem_n;
    logic [31:0]      words_rem, words_rem_n;
    logic [31:0]      rd_addr, rd_addr_n;
    logic             rd_req, rd_req_n;
    logic             ser_load, ser_done;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            hdr       <= '0;
            hdr_rem   <= '0;
            words_rem <= '0;
            rd_addr   <= '0;
            rd_req    <= 1'b0;
        end else begin
            state     <= state_n;
            hdr       <= hdr_n;
            hdr_rem   <= hdr_rem_n;
            words_rem <= words_rem_n;
            rd_addr   <= rd_addr_n;
            rd_req    <= rd_req_n;
        end
    end

    always_comb begin
        state_n     = state;
        hdr_n       = hdr;
        hdr_rem_n   = hdr_rem;
        words_rem_n = words_rem;
        rd_addr_n   = rd_addr;
        rd_req_n    = rd_req;
        ser_load    = 1'b0;
        if (req) begin
            case (state)
                S_IDLE: if (bus.rx_ack) begin
                    hdr_n     = {hdr[HDR_W-BYTE_W-1:0], bus.rx_data};
                    hdr_rem_n = 3'(HDR_BYTES - 1);
                    state_n   = S_RX_HDR;
                end
                S_RX_HDR: if (bus.rx_ack) begin
                    hdr_n     = {hdr[HDR_W-BYTE_W-1:0], bus.rx_data};
                    hdr_rem_n = hdr_rem - 3'd1;
                    if (hdr_rem == 3'd1) state_n = S_LATCH;
                end
                S_LATCH: begin
                    rd_addr_n   = hdr[63:32];
                    words_rem_n = hdr[31:0];
                    if (hdr[31:0] == '0) begin
                        state_n = S_IDLE;
                    end else begin
                        rd_req_n = 1'b1;
                        state_n  = S_RD_WAIT;
                    end
                end
                S_RD_WAIT: if (bus.rd_fin) begin
                    ser_load = 1'b1;
                    rd_req_n = 1'b0;
                    state_n  = S_TX;
                end
                S_TX: if (ser_done) state_n = S_NEXT;
                S_NEXT: begin
                    words_rem_n = words_rem - 32'd1;
                    rd_addr_n   = rd_addr + ADDR_STEP;   // wraps mod 2^32
                    if (words_rem == 32'd1) begin
                        state_n = S_IDLE;
                    end else begin
                        rd_req_n = 1'b1;
                        state_n  = S_RD_WAIT;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    uart_tx_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (req),
        .load    (ser_load),
        .word    (bus.rd_data),
        .ready   (bus.tx_ready),
        .tx_req  (bus.tx_req),
        .tx_data (bus.tx_data),
        .done    (ser_done)
    );

    assign bus.rd_req  = rd_req;
    assign bus.rd_addr = rd_addr;
    assign busy        = (state != S_IDLE);
endmodule

// File: tb/tb_memory_dumper.sv
module tb_memory_dumper;
    logic clk, reset_n, req, busy;
    memory_dumper_if #(.DATA_W(32)) bus ();

    memory_dumper #(.ADDR_STEP(32'd4), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .busy(busy), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] count;
        int          rd_delay;
        int          tx_hold;
        bit          stray;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] got_addr [$];
    logic [7:0]  got_bytes [$];
    int tx_cnt = 0;
    int rd_delay = 1, tx_hold = 1;
    int sd_cnt = 0, u_cnt = 0;
    logic rd_req_prev = 1'b0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SDRAM read port model: rd_fin pulses rd_delay cycles after rd_req.
    always @(posedge clk) begin
        if (!reset_n) begin
            bus.rd_fin = 1'b0; sd_cnt = 0; rd_req_prev = 1'b0;
        end else begin
            if (bus.rd_req && !rd_req_prev) got_addr.push_back(bus.rd_addr);
            rd_req_prev = bus.rd_req;
            if (bus.rd_fin) bus.rd_fin = 1'b0;
            else if (bus.rd_req) begin
                sd_cnt++;
                if (sd_cnt >= rd_delay) begin
                    bus.rd_fin = 1'b1; bus.rd_data = memval(bus.rd_addr); sd_cnt = 0;
                end
            end
        end
    end

    // UART tx model: takes the byte on tx_req, stays busy tx_hold cycles.
    always @(posedge clk) begin
        if (!reset_n) begin
            bus.tx_ready = 1'b1; u_cnt = 0;
        end else if (bus.tx_req) begin
            got_bytes.push_back(bus.tx_data); tx_cnt++;
            bus.tx_ready = 1'b0; u_cnt = tx_hold;
        end else if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) bus.tx_ready = 1'b1;
        end
    end

    task automatic send_header(input logic [31:0] a, input logic [31:0] c);
        logic [63:0] h;
        h = {a, c};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); bus.rx_ack = 1'b1; bus.rx_data = h[63-8*i -: 8];
            @(posedge clk); bus.rx_ack = 1'b0;
        end
    endtask

    // Expected transfer: addresses step by 4 (mod 2^32), bytes MSB first.
    task automatic expect_xfer(input logic [31:0] a, input logic [31:0] c,
                               output logic [31:0] ea [$], output logic [7:0] eb [$]);
        logic [31:0] ad, w;
        ea.delete(); eb.delete();
        for (int i = 0; i < int'(c); i++) begin
            ad = a + 32'(4 * i);
            ea.push_back(ad);
            w = memval(ad);
            for (int b = 3; b >= 0; b--) eb.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic wait_idle(input string name, input bit stray);
        bit done_s = 0, on_s = 0, ok = 0;
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk);
            if (on_s) begin bus.rx_ack = 1'b0; on_s = 0; end
            if (stray && !done_s && got_bytes.size() >= 1) begin
                bus.rx_ack = 1'b1; bus.rx_data = 8'h00; done_s = 1; on_s = 1;
            end
            if (!busy) begin ok = 1; break; end
        end
        bus.rx_ack = 1'b0;
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL %s_timeout: busy still high after 20000 clk", name); end
    endtask

    task automatic compare_stream(input string name, input logic [31:0] ea [$], input logic [7:0] eb [$]);
        chk({name, "_naddr"}, 64'(got_addr.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < got_addr.size(); i++)
            chk($sformatf("%s_addr%0d", name, i), 64'(got_addr[i]), 64'(ea[i]));
        chk({name, "_nbytes"}, 64'(got_bytes.size()), 64'(eb.size()));
        chk({name, "_ntxreq"}, 64'(tx_cnt), 64'(eb.size()));
        for (int i = 0; i < eb.size() && i < got_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 64'(got_bytes[i]), 64'(eb[i]));
        chk({name, "_rdreq_end"}, 64'(bus.rd_req), 64'd0);
    endtask

    task automatic clear_obs();
        got_addr.delete(); got_bytes.delete(); tx_cnt = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] ea [$];
        logic [7:0]  eb [$];
        string nm;
        nm = $sformatf("vec%0d", idx);
        rd_delay = v.rd_delay; tx_hold = v.tx_hold;
        clear_obs();
        expect_xfer(v.addr, v.count, ea, eb);
        send_header(v.addr, v.count);
        chk({nm, "_rdreq_lat1"}, 64'(bus.rd_req), 64'd0);
        @(posedge clk);
        if (v.count == 0) begin
            chk({nm, "_cnt0_idle"}, 64'(busy), 64'd0);
            chk({nm, "_cnt0_rdreq"}, 64'(bus.rd_req), 64'd0);
        end else begin
            chk({nm, "_rdreq_lat2"}, 64'(bus.rd_req), 64'd1);
        end
        wait_idle(nm, v.stray);
        compare_stream(nm, ea, eb);
    endtask

    vec_t vecs [8];

    initial begin
        logic [31:0] ea [$];
        logic [7:0]  eb [$];
        int n;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h104] = 32'h01234567;
        vecs[0] = '{32'h0000_0100, 32'd2, 1, 1, 1'b0};
        vecs[1] = '{32'h0000_0010, 32'd0, 1, 1, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 32'd2, 2, 1, 1'b0};
        vecs[3] = '{32'h0000_2000, 32'd3, 10, 5, 1'b0};
        vecs[4] = '{32'h0000_0300, 32'd2, 1, 2, 1'b1};
        for (int i = 5; i < 8; i++)
            vecs[i] = '{$urandom & 32'hFFFF_FFFC, 32'($urandom_range(1, 3)),
                        int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1))};
        vecs[7].addr = 32'hFFFF_FFF0 | ($urandom & 32'hC);

        reset_n = 1'b0; req = 1'b0; bus.rx_ack = 1'b0; bus.rx_data = 8'h00;
        bus.rd_data = '0; bus.rd_fin = 1'b0; bus.tx_ready = 1'b1;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_txreq", 64'(bus.tx_req), 64'd0);
        chk("rst_txdata", 64'(bus.tx_data), 64'd0);
        chk("rst_rdreq", 64'(bus.rd_req), 64'd0);
        chk("rst_rdaddr", 64'(bus.rd_addr), 64'd0);
        repeat (3) @(posedge clk);
        reset_n = 1'b1; req = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Freeze mid-word: UART stays busy longer than the freeze.
        rd_delay = 2; tx_hold = 30; clear_obs();
        expect_xfer(32'h400, 32'd2, ea, eb);
        send_header(32'h400, 32'd2);
        for (int t = 0; t < 2000 && got_bytes.size() < 2; t++) @(posedge clk);
        req = 1'b0; n = tx_cnt;
        repeat (20) @(posedge clk);
        chk("freeze_no_tx", 64'(tx_cnt), 64'(n));
        chk("freeze_busy", 64'(busy), 64'd1);
        req = 1'b1;
        wait_idle("freeze", 1'b0);
        compare_stream("freeze", ea, eb);

        // Reset during TX_WAIT of the first word.
        rd_delay = 3; tx_hold = 4; clear_obs();
        send_header(32'h500, 32'd3);
        for (int t = 0; t < 2000 && got_bytes.size() < 1; t++) @(posedge clk);
        @(posedge clk);
        reset_n = 1'b0; n = tx_cnt;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_txreq", 64'(bus.tx_req), 64'd0);
        chk("midrst_txdata", 64'(bus.tx_data), 64'd0);
        chk("midrst_rdreq", 64'(bus.rd_req), 64'd0);
        chk("midrst_rdaddr", 64'(bus.rd_addr), 64'd0);
        repeat (3) @(posedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("midrst_no_resend", 64'(tx_cnt), 64'(n));
        chk("midrst_idle", 64'(busy), 64'd0);
        run_vec(8, '{32'h0000_0104, 32'd1, 1, 1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
